// File: rtl/ddr_weight_bank_buf.sv
// ----------------------------------------------------------------------------
// ddr_weight_bank_buf
//
// Multi-bank synapse-weight buffer between the DDR3 read-data channel and the
// synapse datapath. Each bank is an independent circular FIFO. Write and read
// bank selection are independent, so DDR prefetch into one bank can overlap
// consumption from another.
//
// Ports
//   CLK, RST_sync            clock, synchronous active-high reset
//   RD_FIFO_WE/DATA/WR_BANK  DDR beat write strobe, data, target bank
//   RD_REQ/RD_BANK           read request and source bank
//   READ_HOLD                suppresses read requests (no error raised)
//   FLUSH/FLUSH_BANK         empties one bank (pointers and count to zero)
//   ERR_CLR                  clears the sticky OVERFLOW/UNDERFLOW flags
//   SYNARRAY_RDATA/SYN_SIGN  registered weight word and its per-field sign bits
//   RDATA_VALID              one-cycle strobe when the outputs were refreshed
//   BANK_EMPTY/FULL/COUNT    registered per-bank status
//   OVERFLOW/UNDERFLOW       sticky error flags
//
// Read pipeline: accept at edge N (address captured), RAM read registered at
// N+1, output word/sign/valid registered at N+2.
// ----------------------------------------------------------------------------
module ddr_weight_bank_buf #(
  parameter int DW               = 256,
  parameter int AW               = 6,
  parameter int NUM_BANKS        = 2,
  parameter int BANK_W           = 1,
  parameter int OUT_W            = 64,
  parameter int SYN_WEIGHT_WIDTH = 4,
  parameter int SIGN_NUMS        = 16
) (
  input  logic                          CLK,
  input  logic                          RST_sync,
  input  logic                          RD_FIFO_WE,
  input  logic [DW-1:0]                 RD_FIFO_DATA,
  input  logic [BANK_W-1:0]             WR_BANK,
  input  logic                          RD_REQ,
  input  logic [BANK_W-1:0]             RD_BANK,
  input  logic                          READ_HOLD,
  input  logic                          FLUSH,
  input  logic [BANK_W-1:0]             FLUSH_BANK,
  input  logic                          ERR_CLR,
  output logic [OUT_W-1:0]              SYNARRAY_RDATA,
  output logic [SIGN_NUMS-1:0]          SYN_SIGN,
  output logic                          RDATA_VALID,
  output logic [NUM_BANKS-1:0]          BANK_EMPTY,
  output logic [NUM_BANKS-1:0]          BANK_FULL,
  output logic [NUM_BANKS*(AW+1)-1:0]   BANK_COUNT,
  output logic                          OVERFLOW,
  output logic                          UNDERFLOW
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Per-bank FIFO state
  logic [NUM_BANKS-1:0][AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_BANKS-1:0][AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_BANKS-1:0][AW:0]   count_q, count_d;
  logic [NUM_BANKS-1:0]         empty_q, empty_d;
  logic [NUM_BANKS-1:0]         full_q, full_d;

  // Per-bank request decode and accept strobes
  logic [NUM_BANKS-1:0]         wr_hit, rd_hit, fl_hit;
  logic [NUM_BANKS-1:0]         wr_acc, rd_acc;
  logic                         ovf_evt, udf_evt;

  logic                         overflow_q, overflow_d;
  logic                         underflow_q, underflow_d;

  // Read pipeline
  logic                         rd_v1_q, rd_v1_d;
  logic [BANK_W-1:0]            rd_bank1_q, rd_bank1_d;
  logic [AW-1:0]                rd_addr1_q, rd_addr1_d;
  logic                         rd_v2_q, rd_v2_d;
  logic [BANK_W-1:0]            rd_bank2_q, rd_bank2_d;
  logic [NUM_BANKS-1:0][OUT_W-1:0] bank_word;
  logic [OUT_W-1:0]             sel_word;

  logic [OUT_W-1:0]             rdata_q, rdata_d;
  logic [SIGN_NUMS-1:0]         sign_q, sign_d;
  logic                         valid_q, valid_d;

  // Only the low OUT_W bits of a DDR beat are ever presented downstream, so
  // the banks store just that slice.
  if (DW > OUT_W) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^RD_FIFO_DATA[DW-1:OUT_W];
  end

  // Bank RAMs: write at wr_ptr, registered read at the captured address.
  // Every bank reads the same captured address each cycle; the output stage
  // picks the bank the accepted read came from. A write landing on the slot
  // being read in the same cycle returns the old contents (read-first), which
  // is the word that was dequeued.
  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [OUT_W-1:0] mem [DEPTH];
    logic [OUT_W-1:0] word_q;

    always_ff @(posedge CLK) begin
      if (wr_acc[gi]) begin
        mem[wr_ptr_q[gi]] <= RD_FIFO_DATA[OUT_W-1:0];
      end
      word_q <= mem[rd_addr1_q];
    end

    assign bank_word[gi] = word_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    empty_d     = empty_q;
    full_d      = full_q;
    wr_hit      = '0;
    rd_hit      = '0;
    fl_hit      = '0;
    wr_acc      = '0;
    rd_acc      = '0;
    ovf_evt     = 1'b0;
    udf_evt     = 1'b0;
    rd_v1_d     = 1'b0;
    rd_bank1_d  = RD_BANK;
    rd_addr1_d  = rd_addr1_q;

    for (int k = 0; k < NUM_BANKS; k++) begin
      // Indices >= NUM_BANKS never match any bank and are therefore ignored.
      wr_hit[k] = RD_FIFO_WE && (WR_BANK == BANK_W'(k));
      rd_hit[k] = RD_REQ && !READ_HOLD && (RD_BANK == BANK_W'(k));
      fl_hit[k] = FLUSH && (FLUSH_BANK == BANK_W'(k));

      if (fl_hit[k]) begin
        // Flush wins over any same-cycle traffic on this bank, errors included.
        wr_ptr_d[k] = '0;
        rd_ptr_d[k] = '0;
        count_d[k]  = '0;
      end else begin
        // Full/empty are judged on pre-edge state: no fall-through on an
        // empty bank, no write into a full bank even if it is also read.
        wr_acc[k] = wr_hit[k] && !full_q[k];
        rd_acc[k] = rd_hit[k] && !empty_q[k];
        ovf_evt   = ovf_evt || (wr_hit[k] && full_q[k]);
        udf_evt   = udf_evt || (rd_hit[k] && empty_q[k]);

        if (wr_acc[k]) begin
          wr_ptr_d[k] = wr_ptr_q[k] + AW'(1);
        end
        if (rd_acc[k]) begin
          rd_ptr_d[k] = rd_ptr_q[k] + AW'(1);
          rd_v1_d     = 1'b1;
          rd_addr1_d  = rd_ptr_q[k];
        end
        count_d[k] = count_q[k] + (AW+1)'(wr_acc[k]) - (AW+1)'(rd_acc[k]);
      end

      empty_d[k] = (count_d[k] == '0);
      full_d[k]  = (count_d[k] == FULL_CNT);
    end

    // A new error in the clearing cycle keeps the flag set.
    overflow_d  = (overflow_q  && !ERR_CLR) || ovf_evt;
    underflow_d = (underflow_q && !ERR_CLR) || udf_evt;

    rd_v2_d    = rd_v1_q;
    rd_bank2_d = rd_bank1_q;

    sel_word = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (rd_bank2_q == BANK_W'(k)) begin
        sel_word = bank_word[k];
      end
    end

    // Outputs hold their last word until another read completes.
    valid_d = rd_v2_q;
    rdata_d = rdata_q;
    sign_d  = sign_q;
    if (rd_v2_q) begin
      rdata_d = sel_word;
      for (int i = 0; i < SIGN_NUMS; i++) begin
        sign_d[i] = sel_word[SYN_WEIGHT_WIDTH*i + SYN_WEIGHT_WIDTH - 1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= '1;
      full_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_v1_q     <= 1'b0;
      rd_bank1_q  <= '0;
      rd_addr1_q  <= '0;
      rd_v2_q     <= 1'b0;
      rd_bank2_q  <= '0;
      rdata_q     <= '0;
      sign_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_v1_q     <= rd_v1_d;
      rd_bank1_q  <= rd_bank1_d;
      rd_addr1_q  <= rd_addr1_d;
      rd_v2_q     <= rd_v2_d;
      rd_bank2_q  <= rd_bank2_d;
      rdata_q     <= rdata_d;
      sign_q      <= sign_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    BANK_COUNT = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      BANK_COUNT[k*(AW+1) +: (AW+1)] = count_q[k];
    end
  end

  assign SYNARRAY_RDATA = rdata_q;
  assign SYN_SIGN       = sign_q;
  assign RDATA_VALID    = valid_q;
  assign BANK_EMPTY     = empty_q;
  assign BANK_FULL      = full_q;
  assign OVERFLOW       = overflow_q;
  assign UNDERFLOW      = underflow_q;

endmodule
